// File: rtl/reg_scoreboard.sv
// Write-hazard scoreboard for the R0-R14 register file: per-register in-flight write
// counters gate issue until sources are clean; same-cycle writeback bypasses the stall.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 15,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [3:0]          issue_dest,
  input  logic [3:0]          issue_src1,
  input  logic [3:0]          issue_src2,
  input  logic                issue_use_src2,
  input  logic                wb_en,
  input  logic [3:0]          wb_dest,
  output logic                stall,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                busy,
  output logic                err_underflow
);

  localparam int unsigned IDX_N = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0] PC_IDX = 4'd15;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  // Per-index decode over the full 4-bit index space; entries past NUM_REGS stay 0.
  logic [IDX_N-1:0] wb_hit, pend, at_max;
  logic hazard, full;
  logic inc, dec;

  always_comb begin : hit_decode
    wb_hit = '0;
    pend   = '0;
    at_max = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wb_hit[r] = wb_en && (wb_dest == 4'(r));
      pend[r]   = cnt_q[r] > CNT_W'(wb_hit[r]);
      at_max[r] = (cnt_q[r] == CNT_MAX) && !wb_hit[r];
    end
  end

  // Source check happens against pre-issue counts, so self-dependence never stalls.
  always_comb begin : issue_gate
    hazard       = pend[issue_src1] | (issue_use_src2 & pend[issue_src2]);
    full         = issue_wb_en & (issue_dest != PC_IDX) & at_max[issue_dest];
    stall        = issue_valid & (hazard | full);
    issue_accept = issue_valid & ~stall;
  end

  always_comb begin : next_state
    cnt_d = cnt_q;
    err_d = err_q;
    inc   = 1'b0;
    dec   = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc = issue_accept && issue_wb_en && (issue_dest == 4'(r));
      dec = wb_hit[r] && (cnt_q[r] != '0);
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      if (wb_hit[r] && (cnt_q[r] == '0)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin : status_out
    pending_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (cnt_q[r] != '0);
    end
    busy          = |pending_mask;
    err_underflow = err_q;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector bench for reg_scoreboard: table of per-cycle inputs with expected
// combinational issue outputs and the registered status seen before that cycle's edge.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [3:0]  issue_dest;
  logic [3:0]  issue_src1;
  logic [3:0]  issue_src2;
  logic        issue_use_src2;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic        stall;
  logic        issue_accept;
  logic [14:0] pending_mask;
  logic        busy;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_wb_en    (issue_wb_en),
    .issue_dest     (issue_dest),
    .issue_src1     (issue_src1),
    .issue_src2     (issue_src2),
    .issue_use_src2 (issue_use_src2),
    .wb_en          (wb_en),
    .wb_dest        (wb_dest),
    .stall          (stall),
    .issue_accept   (issue_accept),
    .pending_mask   (pending_mask),
    .busy           (busy),
    .err_underflow  (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        wben;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        us2;
    logic        wb;
    logic [3:0]  wbd;
    logic        e_stall;
    logic        e_acc;
    logic [14:0] e_mask;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int r, input int iv, input int wben, input int dest,
                              input int s1, input int s2, input int us2, input int wb,
                              input int wbd, input int st, input int acc, input int mask,
                              input int err);
    vec_t v;
    v.rst = 1'(r);      v.iv = 1'(iv);    v.wben = 1'(wben);
    v.dest = 4'(dest);  v.s1 = 4'(s1);    v.s2 = 4'(s2);
    v.us2 = 1'(us2);    v.wb = 1'(wb);    v.wbd = 4'(wbd);
    v.e_stall = 1'(st); v.e_acc = 1'(acc);
    v.e_mask = 15'(mask); v.e_err = 1'(err);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle at negedge, then compare everything well before the next posedge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    rst            = v.rst;
    issue_valid    = v.iv;
    issue_wb_en    = v.wben;
    issue_dest     = v.dest;
    issue_src1     = v.s1;
    issue_src2     = v.s2;
    issue_use_src2 = v.us2;
    wb_en          = v.wb;
    wb_dest        = v.wbd;
    #1;
    chk({tag, "_stall"},  idx, 32'(stall),         32'(v.e_stall));
    chk({tag, "_accept"}, idx, 32'(issue_accept),  32'(v.e_acc));
    chk({tag, "_mask"},   idx, 32'(pending_mask),  32'(v.e_mask));
    chk({tag, "_busy"},   idx, 32'(busy),          32'(|v.e_mask));
    chk({tag, "_err"},    idx, 32'(err_underflow), 32'(v.e_err));
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0;
    issue_src1 = '0; issue_src2 = '0; issue_use_src2 = 1'b0; wb_en = 1'b0; wb_dest = '0;
    repeat (2) @(negedge clk);

    //          rst iv we dst s1  s2 u2 wb wbd  stl acc mask    err
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 'h0000, 0)); // reset state
    vq.push_back(mk(0, 1, 1, 3,  0,  0, 0, 0, 0,  0, 1, 'h0000, 0)); // issue ->R3
    vq.push_back(mk(0, 1, 0, 0,  3,  0, 0, 0, 0,  1, 0, 'h0008, 0)); // src1 R3 stalls
    vq.push_back(mk(0, 1, 0, 0,  0,  3, 1, 0, 0,  1, 0, 'h0008, 0)); // src2 R3 stalls
    vq.push_back(mk(0, 1, 0, 0,  0,  3, 0, 0, 0,  0, 1, 'h0008, 0)); // immediate form ok
    vq.push_back(mk(0, 1, 0, 0,  3,  0, 0, 1, 3,  0, 1, 'h0008, 0)); // WB bypass R3
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 'h0000, 0));
    vq.push_back(mk(0, 1, 1, 2,  0,  0, 0, 0, 0,  0, 1, 'h0000, 0)); // ->R2
    vq.push_back(mk(0, 1, 1, 2,  0,  2, 0, 1, 2,  0, 1, 'h0004, 0)); // inc+dec R2
    vq.push_back(mk(0, 1, 0, 0,  0,  2, 0, 0, 0,  0, 1, 'h0004, 0));
    vq.push_back(mk(0, 1, 0, 0,  2,  0, 0, 0, 0,  1, 0, 'h0004, 0)); // R2 still held
    vq.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0, 0,  0, 1, 'h0004, 0)); // R5 cnt 1
    vq.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0, 0,  0, 1, 'h0024, 0)); // R5 cnt 2
    vq.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0, 0,  0, 1, 'h0024, 0)); // R5 cnt 3
    vq.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0, 0,  1, 0, 'h0024, 0)); // full stall
    vq.push_back(mk(0, 1, 1, 5,  0,  0, 0, 1, 5,  0, 1, 'h0024, 0)); // full lifted by WB
    vq.push_back(mk(0, 1, 1, 5,  0,  0, 0, 0, 0,  1, 0, 'h0024, 0)); // cnt stayed 3
    vq.push_back(mk(0, 1, 1, 6,  6,  0, 0, 0, 0,  0, 1, 'h0024, 0)); // self-dependence
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 'h0064, 0));
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 7,  0, 0, 'h0064, 0)); // underflow R7
    vq.push_back(mk(0, 1, 1, 15, 0,  0, 0, 0, 0,  0, 1, 'h0064, 1)); // dest PC uncounted
    vq.push_back(mk(0, 1, 0, 0,  15, 15,1, 1, 15, 0, 1, 'h0064, 1)); // PC src / WB ignored
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0, 'h0064, 1));
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 5,  0, 0, 'h0064, 1)); // R5 3->2
    vq.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 2,  0, 0, 'h0064, 1)); // R2 1->0
    vq.push_back(mk(0, 0, 0, 0,  5,  0, 0, 0, 0,  0, 0, 'h0060, 1)); // no stall w/o valid
    vq.push_back(mk(0, 1, 1, 1,  0,  0, 0, 0, 0,  0, 1, 'h0060, 1)); // ->R1
    vq.push_back(mk(0, 1, 1, 4,  0,  0, 0, 0, 0,  0, 1, 'h0062, 1)); // ->R4
    vq.push_back(mk(1, 1, 1, 4,  0,  0, 0, 1, 9,  0, 1, 'h0072, 1)); // reset mid-stream
    vq.push_back(mk(0, 1, 0, 0,  1,  4, 1, 0, 0,  0, 1, 'h0000, 0)); // all cleared

    foreach (vq[i]) apply(vq[i], "vec", i);

    // Drain R10 from MAX while a src2 consumer waits; it issues on the last WB cycle.
    apply(mk(0, 1, 1, 10, 0, 0,  0, 0, 0,  0, 1, 'h0000, 0), "drain", 0);
    apply(mk(0, 1, 1, 10, 0, 0,  0, 0, 0,  0, 1, 'h0400, 0), "drain", 1);
    apply(mk(0, 1, 1, 10, 0, 0,  0, 0, 0,  0, 1, 'h0400, 0), "drain", 2);
    apply(mk(0, 1, 0, 0,  0, 10, 1, 1, 10, 1, 0, 'h0400, 0), "drain", 3);
    apply(mk(0, 1, 0, 0,  0, 10, 1, 1, 10, 1, 0, 'h0400, 0), "drain", 4);
    apply(mk(0, 1, 0, 0,  0, 10, 1, 1, 10, 0, 1, 'h0400, 0), "drain", 5);
    apply(mk(0, 0, 0, 0,  0, 0,  0, 1, 10, 0, 0, 'h0000, 0), "drain", 6);
    apply(mk(0, 0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 'h0000, 1), "drain", 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
